renkon_serial_mat: RTL and testbench
====================================

// Module: renkon_serial_mat
// PURPOSE
//  Output serializer directly downstream of renkon_ctrl_core. Captures one result word per core
//  per pixel into per-core buffers, then replays core 1..RENKON_CORE buffers one after another as a
//  single word stream.
//  out_wdata feeds ctrl_core's out_wdata, which ctrl_core drives to image memory in S_OUTPUT.
//  Timing is fixed by ctrl_core: out_wdata appears 2 cycles after the serial_re/serial_addr that
//  selected it.
// PARAMETERS (from renkon.svh package, not overridden locally)
//  RENKON_CORE     8   number of parallel cores / buffers
//  RENKON_CORELOG  3   log2(RENKON_CORE)
//  OUTSIZE         10  buffer address width; depth = 2**OUTSIZE words per core
//  DWIDTH          16  signed data width
// PORTS
//  clk          in   1                    clock, rising edge
//  xrst         in   1                    synchronous active-low reset
//  serial_we    in   1                    write all core words at serial_addr
//  serial_re    in   RENKON_CORELOG+1     0 = idle; k in 1..RENKON_CORE = read core k-1
//  serial_addr  in   OUTSIZE              shared write/read address
//  in_data      in   RENKON_CORE*DWIDTH   signed packed; core i in bits [i*DWIDTH +: DWIDTH]
//  out_wdata    out  DWIDTH               signed serialized word, to ctrl_core out_wdata
//  out_valid    out  1                    out_wdata carries a read result (monitor/debug)
//  re_err       out  1                    sticky: serial_re > RENKON_CORE was seen
// BEHAVIOUR
//  Reset (xrst=0 at a clk edge): out_wdata=0, out_valid=0, re_err=0.
//   - All pipeline stage registers are cleared.
//   - Buffer contents are not reset.
//  Write:
//   - serial_we=1 at edge t writes in_data word i into buf[i][serial_addr] for every i, same cycle.
//  Read pipeline, 2 cycles:
//   - Stage 1 (edge t): if 1<=serial_re<=RENKON_CORE, latch r_sel=serial_re-1,
//     r_rd = buf[r_sel][serial_addr] (registered RAM read) and r_v1=1.
//   - Stage 1 otherwise: r_v1=0.
//   - Stage 2 (edge t+1): out_wdata <= r_v1 ? r_rd : 0; out_valid <= r_v1.
//   - Net: data visible during the cycle after edge t+1, aligned with ctrl_core r_img_we.
//  Idle: serial_re=0 -> out_wdata returns to 0 and out_valid to 0, two cycles later.
//  Back-to-back reads: one word per cycle sustained, no bubbles.
//   - Core switch (k -> k+1 with addr wrap to 0) adds no bubble.
//  Write/read collision (serial_we and serial_re>0, same serial_addr, same cycle): read returns
//  the OLD contents (read-before-write).
//  Address wrap: serial_addr is used modulo 2**OUTSIZE; no internal address counter exists.
//  Out-of-range serial_re (RENKON_CORE < serial_re <= 2**(RENKON_CORELOG+1)-1):
//   - treated as idle (out_valid=0, out_wdata=0) and re_err set.
//   - re_err clears only on reset.
//  Reset mid-stream: in-flight stage-1/stage-2 results are discarded; outputs are 0 on the next
//  cycle.
//   - Buffers keep old data, which may be re-read after reset.
//  in_data sign is preserved bit-exact; no arithmetic in this block.
// STRUCTURE
//  Package renkon.svh supplies RENKON_CORE, RENKON_CORELOG, OUTSIZE, DWIDTH; no new typedefs.
//  One sub-module: renkon_serial_buf, a single-port-write / registered-read RAM of
//  DWIDTH x 2**OUTSIZE with read-before-write.
//   - Instantiated RENKON_CORE times via generate.
//   - Each instance reads every cycle.
//   - The top level muxes by r_sel.
//  Top level holds: the stage-1 select/valid regs, the output mux register, and re_err.
// TESTING
//  1 Fill: serial_we for addr 0..3, core i word = 100*i+addr. Then serial_re=1..8 with addr 0..3
//    each (32 cycles).
//    -> out_wdata sequence 0,1,2,3,100,...,703.
//    -> out_valid high for exactly 32 cycles, 2 cycles after first re.
//  2 Collision: buf[0][5]=7. Same cycle: serial_we with core0=-9 at addr 5, and serial_re=1 at
//    addr 5.
//    -> out_wdata=7 (two cycles later).
//    -> A repeated read -> -9 (0xFFF7).
//  3 Wrap: write addr 2**OUTSIZE-1 = 1023 and addr 0. Read re=2 at addr 1023 then addr 0 on
//    consecutive cycles.
//    -> both words back-to-back, no bubble.
//  4 Bad select: serial_re=9 for 1 cycle.
//    -> out_valid=0, out_wdata=0.
//    -> re_err=1 from the next cycle and stays 1 until xrst=0.
//  5 Reset mid-read: xrst=0 for 1 cycle during a read burst.
//    -> out_wdata=0, out_valid=0, re_err=0 the next cycle.
//    -> Re-reading addr 0 afterwards returns pre-reset data.
//  6 Integrated with renkon_ctrl_core (total_out=16, total_in=2):
//    -> image memory at out_offset receives core-ordered words matching the golden model.

Source files
------------

// File: rtl/renkon_serial_mat_pkg.sv
// Shared sizing for the renkon output serializer: core count, buffer depth and word width.
// The select decode helper is shared so the top level and any future users agree on the legal range.
package renkon_serial_mat_pkg;

   localparam int RENKON_CORE    = 8;
   localparam int RENKON_CORELOG = 3;
   localparam int OUTSIZE        = 10;
   localparam int DWIDTH         = 16;

   // 0 means idle; 1..RENKON_CORE selects a core; anything above is illegal.
   function automatic logic sel_in_range(input logic [RENKON_CORELOG:0] sel);
      return (sel != '0) && (sel <= (RENKON_CORELOG+1)'(RENKON_CORE));
   endfunction

endpackage

// File: rtl/renkon_serial_mat_buf.sv
// One per-core result buffer: single write port, registered read every cycle.
// A same-address write and read return the previous contents (read-before-write).
module renkon_serial_buf
   import renkon_serial_mat_pkg::*;
(
   input  logic                     clk,
   input  logic                     we,
   input  logic [OUTSIZE-1:0]       addr,
   input  logic signed [DWIDTH-1:0] wdata,
   output logic signed [DWIDTH-1:0] rdata
);

   logic signed [DWIDTH-1:0] mem [2**OUTSIZE];

   // No reset on the array or read register so this maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/renkon_serial_mat.sv
// Output serializer behind renkon_ctrl_core: buffers one word per core per pixel and replays
// the buffers core by core, with out_wdata two cycles after the serial_re/serial_addr that chose it.
module renkon_serial_mat
   import renkon_serial_mat_pkg::*;
(
   input  logic                            clk,
   input  logic                            xrst,
   input  logic                            serial_we,
   input  logic [RENKON_CORELOG:0]         serial_re,
   input  logic [OUTSIZE-1:0]              serial_addr,
   input  logic [RENKON_CORE*DWIDTH-1:0]   in_data,
   output logic signed [DWIDTH-1:0]        out_wdata,
   output logic                            out_valid,
   output logic                            re_err
);

   logic signed [DWIDTH-1:0]  rd_word [RENKON_CORE];
   logic [RENKON_CORELOG-1:0] r_sel;
   logic                      r_v1;
   logic                      re_ok;
   logic                      re_bad;
   logic signed [DWIDTH-1:0]  rd_mux;

   genvar gi;
   generate
      for (gi = 0; gi < RENKON_CORE; gi++) begin : g_buf
         renkon_serial_buf u_buf (
            .clk   (clk),
            .we    (serial_we),
            .addr  (serial_addr),
            .wdata (in_data[gi*DWIDTH +: DWIDTH]),
            .rdata (rd_word[gi])
         );
      end
   endgenerate

   always_comb begin
      re_ok  = sel_in_range(serial_re);
      re_bad = (serial_re > (RENKON_CORELOG+1)'(RENKON_CORE));
      rd_mux = rd_word[r_sel];
   end

   // Stage 1 runs alongside the RAM read; select k maps to core k-1 (8 wraps to 7 in 3 bits).
   always_ff @(posedge clk) begin
      if (!xrst) begin
         r_sel <= '0;
         r_v1  <= 1'b0;
      end else begin
         r_v1 <= re_ok;
         if (re_ok) begin
            r_sel <= serial_re[RENKON_CORELOG-1:0] - RENKON_CORELOG'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!xrst) begin
         out_wdata <= '0;
         out_valid <= 1'b0;
         re_err    <= 1'b0;
      end else begin
         out_wdata <= r_v1 ? rd_mux : '0;
         out_valid <= r_v1;
         if (re_bad) begin
            re_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_renkon_serial_mat.sv
// Scoreboard bench for renkon_serial_mat: the stimulus pushes expected words into a queue,
// and a negedge monitor pops and compares them whenever out_valid is high.
module tb_renkon_serial_mat;

   logic          clk = 1'b0;
   logic          xrst;
   logic          serial_we;
   logic [3:0]    serial_re;
   logic [9:0]    serial_addr;
   logic [127:0]  in_data;
   logic signed [15:0] out_wdata;
   logic          out_valid;
   logic          re_err;

   renkon_serial_mat dut (
      .clk         (clk),
      .xrst        (xrst),
      .serial_we   (serial_we),
      .serial_re   (serial_re),
      .serial_addr (serial_addr),
      .in_data     (in_data),
      .out_wdata   (out_wdata),
      .out_valid   (out_valid),
      .re_err      (re_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          cyc;
      int          core;
      int          addr;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] model [8][1024];
   int          cyc      = 0;
   int          checks   = 0;
   int          failures = 0;
   int          err_from = -1;
   int          skip_err = -1;
   bit          mon_en   = 1'b0;

   always @(posedge clk) cyc++;

   // Reference: reads see the buffer before this cycle's write; data lands 2 cycles after issue.
   task automatic step(input logic we, input logic [3:0] re, input logic [9:0] addr,
                       input logic [127:0] d);
      exp_t e;
      serial_we   = we;
      serial_re   = re;
      serial_addr = addr;
      in_data     = d;
      if (re >= 1 && re <= 8) begin
         e.data = model[re-1][addr];
         e.cyc  = cyc + 2;
         e.core = re - 1;
         e.addr = addr;
         sb_q.push_back(e);
      end else if (re > 8 && err_from < 0) begin
         err_from = cyc + 1;
      end
      if (we) begin
         for (int i = 0; i < 8; i++) model[i][addr] = d[i*16 +: 16];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 10'd0, '0);
   endtask

   // Results due after the reset edge are dropped; anything due this cycle still appears.
   task automatic pulse_reset(input logic [3:0] re, input logic [9:0] addr);
      exp_t keep[$];
      serial_we   = 1'b0;
      serial_re   = re;
      serial_addr = addr;
      xrst        = 1'b0;
      foreach (sb_q[i]) if (sb_q[i].cyc <= cyc) keep.push_back(sb_q[i]);
      sb_q     = keep;
      err_from = -1;
      skip_err = cyc;
      @(posedge clk);
      #1;
      xrst = 1'b1;
   endtask

   function automatic logic [127:0] pattern(input int addr);
      logic [127:0] d;
      for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(100*i + addr);
      return d;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         logic exp_err;
         if (cyc != skip_err) begin
            exp_err = (err_from >= 0) && (cyc >= err_from);
            checks++;
            if (re_err !== exp_err) begin
               failures++;
               $display("FAIL re_err cyc=%0d actual=%b required=%b", cyc, re_err, exp_err);
            end
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid cyc=%0d actual=%0d required=none", cyc, out_wdata);
            end else begin
               e = sb_q.pop_front();
               if (out_wdata !== e.data || e.cyc != cyc) begin
                  failures++;
                  $display("FAIL read core=%0d addr=%0d actual=%h@%0d required=%h@%0d",
                           e.core, e.addr, out_wdata, cyc, e.data, e.cyc);
               end else begin
                  $display("read core=%0d addr=%0d data=%h cyc=%0d", e.core, e.addr, out_wdata, cyc);
               end
            end
         end else begin
            checks++;
            if (out_valid !== 1'b0 || out_wdata !== 16'sd0) begin
               failures++;
               $display("FAIL idle_out cyc=%0d actual=%b/%h required=0/0000", cyc, out_valid, out_wdata);
            end
            if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
               e = sb_q.pop_front();
               failures++;
               $display("FAIL missing core=%0d addr=%0d actual=none required=%h@%0d",
                        e.core, e.addr, e.data, e.cyc);
            end
         end
      end
   end

   initial begin
      logic [127:0] d;
      int addrs[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 1020, 1021, 1022, 1023};
      xrst = 1'b0; serial_we = 1'b0; serial_re = '0; serial_addr = '0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      xrst   = 1'b1;
      idle(2);

      // Fill then replay cores 1..8 over addr 0..3
      for (int a = 0; a < 4; a++) step(1'b1, 4'd0, 10'(a), pattern(a));
      for (int k = 1; k <= 8; k++)
         for (int a = 0; a < 4; a++) step(1'b0, 4'(k), 10'(a), '0);
      idle(3);

      // Collision: old value first, new value on repeat
      d = '0; d[15:0] = 16'sd7;
      step(1'b1, 4'd0, 10'd5, d);
      d[15:0] = -16'sd9;
      step(1'b1, 4'd1, 10'd5, d);
      step(1'b0, 4'd1, 10'd5, '0);
      idle(3);

      // Address wrap, back-to-back on core 2
      d = '0; d[31:16] = 16'h1234;
      step(1'b1, 4'd0, 10'd1023, d);
      d[31:16] = 16'h8765;
      step(1'b1, 4'd0, 10'd0, d);
      step(1'b0, 4'd2, 10'd1023, '0);
      step(1'b0, 4'd2, 10'd0, '0);
      idle(3);

      // Random traffic over a known address set, legal selects only
      foreach (addrs[i]) step(1'b1, 4'd0, 10'(addrs[i]), {$urandom, $urandom, $urandom, $urandom});
      for (int n = 0; n < 200; n++)
         step(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 8)),
              10'(addrs[$urandom_range(0, 11)]), {$urandom, $urandom, $urandom, $urandom});
      idle(3);

      // Bad select makes re_err sticky
      step(1'b0, 4'd9, 10'd0, '0);
      idle(2);
      for (int n = 0; n < 100; n++)
         step(1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
              10'(addrs[$urandom_range(0, 11)]), {$urandom, $urandom, $urandom, $urandom});
      idle(3);

      // Reset in the middle of a read burst, then re-read pre-reset data
      for (int a = 0; a < 4; a++) step(1'b1, 4'd0, 10'(a), pattern(a + 40));
      step(1'b0, 4'd1, 10'd0, '0);
      step(1'b0, 4'd1, 10'd1, '0);
      pulse_reset(4'd1, 10'd2);
      step(1'b0, 4'd1, 10'd3, '0);
      step(1'b0, 4'd1, 10'd0, '0);
      step(1'b0, 4'd8, 10'd0, '0);
      idle(4);

      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
